tinyalu_arbiter: RTL and testbench

//  Shares one tinyalu among N_REQ requesters. Round-robin pick, then drives the ALU's
//  A/B/op/start; holds start until done; returns the 16-bit result to the winner.

---
 rtl/tinyalu_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/tinyalu_arbiter.sv | 143 ++++++++++++++
 tb/tb_tinyalu_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tinyalu_pkg.sv
// Shared types and constants for the tinyalu arbiter slice.
// Optional feature macro used by the arbiter: TINYALU_ARB_TIMEOUT_EN.
package tinyalu_pkg;

   typedef enum logic [2:0] {
      no_op  = 3'd0,
      add_op = 3'd1,
      and_op = 3'd2,
      xor_op = 3'd3,
      mul_op = 3'd4,
      rst_op = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } arb_state_t;

   localparam logic [15:0] TIMEOUT_RESULT = 16'hDEAD;

   // True for opcodes that need the ALU; no_op, rst_op and undefined codes are answered locally.
   function automatic logic uses_alu(input logic [2:0] op);
      logic r;
      case (op)
         add_op, and_op, xor_op, mul_op: r = 1'b1;
         default:                        r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned N = 4,
   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] idx
);

   logic        found;
   int unsigned pos;

   // Scan requests starting at ptr; the first hit wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = (32'(ptr) + k) % N;
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            idx        = PW'(pos);
         end
      end
   end

endmodule

// File: rtl/tinyalu_arbiter.sv
// Round-robin front end sharing one tinyalu among N_REQ requesters.
// Optional watchdog in ISSUE enabled by defining TINYALU_ARB_TIMEOUT_EN.
module tinyalu_arbiter
   import tinyalu_pkg::*;
#(
   parameter int unsigned N_REQ          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ*8-1:0] req_a,
   input  logic [N_REQ*8-1:0] req_b,
   input  logic [N_REQ*3-1:0] req_op,
   output logic [N_REQ-1:0]   req_ready,
   output logic [N_REQ-1:0]   rsp_valid,
   output logic [15:0]        rsp_result,
   output logic               rsp_error,
   output logic [7:0]         alu_a,
   output logic [7:0]         alu_b,
   output logic [2:0]         alu_op,
   output logic               alu_start,
   output logic               alu_reset_n,
   input  logic               alu_done,
   input  logic [15:0]        alu_result
);

   localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   arb_state_t    state_q, state_d;
   logic [PW-1:0] rr_ptr_q, rr_next, win_idx, lat_id_q;
   logic [N_REQ-1:0] grant;
   logic [7:0]    sel_a, sel_b, lat_a_q, lat_b_q;
   logic [2:0]    sel_op, lat_op_q;
   logic          sel_alu, accept, tmo_hit, tmo_pulse;
   logic [15:0]   res_q;

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .grant (grant),
      .idx   (win_idx)
   );

   assign sel_a   = req_a[8*win_idx +: 8];
   assign sel_b   = req_b[8*win_idx +: 8];
   assign sel_op  = req_op[3*win_idx +: 3];
   assign sel_alu = uses_alu(sel_op);
   assign accept  = (state_q == IDLE) && (|req_valid);
   assign rr_next = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

`ifdef TINYALU_ARB_TIMEOUT_EN
   logic [15:0] tmo_cnt_q;
   logic        err_q;

   assign tmo_hit   = (state_q == ISSUE) && !alu_done && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
   assign tmo_pulse = (state_q == RESP) && err_q;
   assign rsp_error = !reset && tmo_pulse;

   // Watchdog: counts ISSUE cycles, flags a timed-out transaction until the next accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else if (accept) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else if (state_q == ISSUE) begin
         tmo_cnt_q <= tmo_cnt_q + 16'd1;
         if (tmo_hit) err_q <= 1'b1;
      end
   end
`else
   assign tmo_hit   = 1'b0;
   assign tmo_pulse = 1'b0;
   assign rsp_error = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|req_valid) state_d = sel_alu ? ISSUE : RESP;
         ISSUE:   if (alu_done || tmo_hit) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Transaction latches, rr pointer and held response value.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q <= '0;
         lat_id_q <= '0;
         lat_a_q  <= '0;
         lat_b_q  <= '0;
         lat_op_q <= '0;
         res_q    <= '0;
      end else if (accept) begin
         rr_ptr_q <= rr_next;
         lat_id_q <= win_idx;
         lat_a_q  <= sel_a;
         lat_b_q  <= sel_b;
         lat_op_q <= sel_op;
         if (!sel_alu) res_q <= '0;
      end else if (state_q == ISSUE) begin
         if (alu_done)     res_q <= alu_result;
         else if (tmo_hit) res_q <= TIMEOUT_RESULT;
      end
   end

   // Outputs; everything forced low while reset is asserted.
   always_comb begin
      req_ready   = '0;
      rsp_valid   = '0;
      alu_start   = 1'b0;
      alu_a       = '0;
      alu_b       = '0;
      alu_op      = '0;
      rsp_result  = reset ? '0 : res_q;
      alu_reset_n = !(reset || tmo_pulse);
      if (!reset) begin
         case (state_q)
            IDLE:  req_ready = grant;
            ISSUE: begin
               alu_start = 1'b1;
               alu_a     = lat_a_q;
               alu_b     = lat_b_q;
               alu_op    = lat_op_q;
            end
            RESP:  rsp_valid[lat_id_q] = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Directed self-checking bench for tinyalu_arbiter with a behavioural tinyalu model.
// Test 6 depends on TINYALU_ARB_TIMEOUT_EN.
module tb_tinyalu_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_a, req_b;
   logic [11:0] req_op;
   logic [3:0]  req_ready, rsp_valid;
   logic [15:0] rsp_result;
   logic        rsp_error;
   logic [7:0]  alu_a, alu_b;
   logic [2:0]  alu_op;
   logic        alu_start, alu_reset_n;
   logic        alu_done;
   logic [15:0] alu_result;

   int errors = 0;
   int checks = 0;
   logic rsp_seen, start_seen;
   logic hang = 1'b0;
   int   mcnt = 0;
   int   n;

   tinyalu_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_op(req_op), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
      .rsp_error(rsp_error), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_start(alu_start), .alu_reset_n(alu_reset_n), .alu_done(alu_done),
      .alu_result(alu_result)
   );

   always #5 clk = ~clk;

   // ALU model: 1-cycle ops, 3-cycle mul, done pulses once; never done when hang is set.
   always @(posedge clk) begin
      if (!alu_reset_n) begin
         mcnt     <= 0;
         alu_done <= 1'b0;
      end else if (alu_start && !alu_done && !hang) begin
         mcnt <= mcnt + 1;
         if (mcnt + 1 == ((alu_op == 3'd4) ? 3 : 1)) begin
            alu_done <= 1'b1;
            case (alu_op)
               3'd1: alu_result <= 16'(alu_a) + 16'(alu_b);
               3'd2: alu_result <= {8'h00, alu_a & alu_b};
               3'd3: alu_result <= {8'h00, alu_a ^ alu_b};
               default: alu_result <= 16'(alu_a) * 16'(alu_b);
            endcase
         end
      end else begin
         mcnt     <= 0;
         alu_done <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      rsp_seen   = rsp_seen | (|rsp_valid);
      start_seen = start_seen | alu_start;
   endtask

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      req_a[8*i +: 8]  = a;
      req_b[8*i +: 8]  = b;
      req_op[3*i +: 3] = op;
      req_valid[i]     = 1'b1;
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (alu_done !== 1'b1 && k < 30) begin
         step();
         k++;
      end
      check(tag, alu_done, 1);
   endtask

   initial begin
      reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
      alu_done = 1'b0; alu_result = '0; rsp_seen = 1'b0; start_seen = 1'b0;

      // Reset state
      step(); step();
      check("rst_ready", req_ready, 0);
      check("rst_rspv", rsp_valid, 0);
      check("rst_start", alu_start, 0);
      check("rst_alurstn", alu_reset_n, 0);
      check("rst_result", rsp_result, 0);
      check("rst_err", rsp_error, 0);
      reset = 1'b0;
      step();
      check("rel_alurstn", alu_reset_n, 1);

      // 1: req0 add 3+5
      set_req(0, 8'd3, 8'd5, 3'd1);
      #1 check("t1_ready", req_ready, 4'b0001);
      step();
      req_valid = '0;
      check("t1_start", alu_start, 1);
      check("t1_ops", {alu_a, alu_b, 5'b0, alu_op}, {8'd3, 8'd5, 8'd1});
      wait_done("t1_done");
      step();
      check("t1_rspv", rsp_valid, 4'b0001);
      check("t1_result", rsp_result, 16'd8);
      step();
      check("t1_rspv_off", rsp_valid, 0);
      check("t1_hold", rsp_result, 16'd8);

      // 2: req0 mul 3*5, start held through the multi-cycle op
      set_req(0, 8'd3, 8'd5, 3'd4);
      #1 check("t2_ready", req_ready, 4'b0001);
      step();
      req_valid = '0;
      start_seen = 1'b0;
      n = 0;
      while (alu_done !== 1'b1 && n < 30) begin
         check("t2_start_held", alu_start, 1);
         step();
         n++;
      end
      check("t2_mul_cycles", n, 3);
      step();
      check("t2_rspv", rsp_valid, 4'b0001);
      check("t2_result", rsp_result, 16'd15);
      rsp_seen = 1'b0;
      step(); step(); step();
      check("t2_single_pulse", rsp_seen, 0);

      // 3: all four valid continuously after reset -> 0,1,2,3,0
      reset = 1'b1; step(); reset = 1'b0; step();
      for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 8'd10, 3'd1);
      for (int k = 0; k < 5; k++) begin
         #1 check("t3_grant", req_ready, 4'b0001 << (k % 4));
         step();
         check("t3_start", alu_start, 1);
         wait_done("t3_done");
         step();
         check("t3_rspv", rsp_valid, 4'b0001 << (k % 4));
         check("t3_result", rsp_result, 32'((k % 4) + 11));
         check("t3_gap", alu_start, 0);
         if (k == 4) req_valid = '0;
         step();
      end

      // 4: local ops on req2 (pointer is 1, then 3 so the pick wraps)
      start_seen = 1'b0;
      set_req(2, 8'd9, 8'd9, 3'd0);
      #1 check("t4_noop_ready", req_ready, 4'b0100);
      step();
      req_valid = '0;
      check("t4_noop_rspv", rsp_valid, 4'b0100);
      check("t4_noop_result", rsp_result, 0);
      step();
      set_req(2, 8'd9, 8'd9, 3'd7);
      #1 check("t4_rstop_ready", req_ready, 4'b0100);
      step();
      req_valid = '0;
      check("t4_rstop_rspv", rsp_valid, 4'b0100);
      check("t4_rstop_result", rsp_result, 0);
      step();
      set_req(2, 8'd9, 8'd9, 3'd5);
      #1;
      step();
      req_valid = '0;
      check("t4_undef_rspv", rsp_valid, 4'b0100);
      step();
      check("t4_no_start", start_seen, 0);

      // 5: reset in the middle of a mul
      set_req(0, 8'd7, 8'd6, 3'd4);
      #1 check("t5_ready", req_ready, 4'b0001);
      step();
      req_valid = '0;
      step();
      check("t5_in_issue", alu_start, 1);
      reset = 1'b1;
      rsp_seen = 1'b0;
      #1 check("t5_alurstn", alu_reset_n, 0);
      step(); step();
      reset = 1'b0;
      set_req(0, 8'd2, 8'd2, 3'd3);
      set_req(1, 8'd4, 8'd4, 3'd1);
      #1 check("t5_ptr_reset", req_ready, 4'b0001);
      check("t5_no_rsp", rsp_seen, 0);
      step();
      req_valid = '0;
      wait_done("t5_done");
      step();
      check("t5_rsp_result", rsp_result, 0);
      step();

      // 6: ALU never completes
      hang = 1'b1;
      set_req(1, 8'd1, 8'd1, 3'd1);
      #1 check("t6_ready", req_ready, 4'b0010);
      step();
      req_valid = '0;
      rsp_seen = 1'b0;
`ifdef TINYALU_ARB_TIMEOUT_EN
      n = 0;
      while (alu_start === 1'b1 && n < 40) begin
         n++;
         step();
      end
      check("t6_issue_cycles", n, 16);
      check("t6_rspv", rsp_valid, 4'b0010);
      check("t6_result", rsp_result, 16'hDEAD);
      check("t6_err", rsp_error, 1);
      check("t6_alurstn_pulse", alu_reset_n, 0);
      step();
      check("t6_err_clear", rsp_error, 0);
      check("t6_alurstn_back", alu_reset_n, 1);
`else
      for (int k = 0; k < 40; k++) step();
      check("t6_still_issue", alu_start, 1);
      check("t6_no_rsp", rsp_seen, 0);
      check("t6_no_err", rsp_error, 0);
      reset = 1'b1; step(); reset = 1'b0; step();
`endif
      hang = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
